// File: rtl/cpu_pkg.sv
// Shared CPU encodings: branch types, ALU opcodes and default datapath widths.
package cpu_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_RD_W   = 6;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_Z    = 2'b01,
        BR_N    = 2'b10,
        BR_JUMP = 2'b11
    } br_type_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b101,
        ALU_NEG  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    function automatic logic br_is_cond(input logic [1:0] br_type);
        return (br_type == BR_Z) || (br_type == BR_N);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision from branch type and the architectural Z/N flags.
module branch_resolve
    import cpu_pkg::*;
(
    input  logic [1:0] br_type,
    input  logic       flag_z,
    input  logic       flag_n,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (br_type)
            BR_NONE: taken = 1'b0;
            BR_Z:    taken = flag_z;
            BR_N:    taken = flag_n;
            BR_JUMP: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural flag register, branch
// resolution, a single-pulse fetch redirect and a saturating taken-branch counter.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_W   = DEF_RD_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic [DATA_W-1:0] store_data,
    input  logic [RD_W-1:0]   rd_addr,
    input  logic              reg_wr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              set_flags,
    input  logic [1:0]        br_type,
    input  logic [DATA_W-1:0] br_target,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_store_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_wr,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              flag_z,
    output logic              flag_n,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  taken_cnt
);

    logic acc;
    logic adv;
    logic taken;
    logic out_taken;
    logic redirect_done;

    // Flush overrides stall, so the stage advances whenever either is absent/flush wins.
    assign acc = in_valid & ~stall & ~flush;
    assign adv = ~stall | flush;

    // Resolution uses the flag register before this cycle's update.
    branch_resolve u_branch_resolve (
        .br_type (br_type),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .taken   (taken)
    );

    // Control fields: bubble on any advancing edge without a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_reg_wr <= 1'b0;
            out_mem_rd <= 1'b0;
            out_mem_wr <= 1'b0;
            out_taken  <= 1'b0;
        end else if (adv) begin
            out_valid  <= acc;
            out_reg_wr <= acc & reg_wr;
            out_mem_rd <= acc & mem_rd;
            out_mem_wr <= acc & mem_wr;
            out_taken  <= acc & taken;
        end
    end

    // Data fields only move on a capture; bubbles leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_alu        <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
        end else if (acc) begin
            out_alu        <= alu_out;
            out_store_data <= store_data;
            out_rd         <= rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (acc && set_flags) begin
            flag_z <= alu_z;
            flag_n <= alu_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc <= '0;
            taken_cnt   <= '0;
        end else if (acc && taken) begin
            redirect_pc <= br_target;
            if (taken_cnt != {CNT_W{1'b1}}) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

    // Remembers that the pulse for the held branch already fired during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_done <= 1'b0;
        end else if (adv) begin
            redirect_done <= 1'b0;
        end else if (redirect) begin
            redirect_done <= 1'b1;
        end
    end

    assign redirect = out_valid & out_taken & ~redirect_done;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus randomized bench for ex_mem_stage against a transaction-level model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush;
    logic [31:0] alu_out, store_data, br_target;
    logic        alu_z, alu_n, reg_wr, mem_rd, mem_wr, set_flags;
    logic [5:0]  rd_addr;
    logic [1:0]  br_type;

    logic        out_valid, out_reg_wr, out_mem_rd, out_mem_wr, flag_z, flag_n, redirect;
    logic [31:0] out_alu, out_store_data, redirect_pc;
    logic [5:0]  out_rd;
    logic [15:0] taken_cnt;

    logic        c2_valid, c2_reg_wr, c2_mem_rd, c2_mem_wr, c2_fz, c2_fn, c2_redirect;
    logic [31:0] c2_alu, c2_store_data, c2_redirect_pc;
    logic [5:0]  c2_rd;
    logic [1:0]  c2_taken_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_mem_stage u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .store_data(store_data),
        .rd_addr(rd_addr), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .set_flags(set_flags), .br_type(br_type), .br_target(br_target),
        .out_valid(out_valid), .out_alu(out_alu), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_reg_wr(out_reg_wr), .out_mem_rd(out_mem_rd),
        .out_mem_wr(out_mem_wr), .flag_z(flag_z), .flag_n(flag_n), .redirect(redirect),
        .redirect_pc(redirect_pc), .taken_cnt(taken_cnt)
    );

    ex_mem_stage #(.CNT_W(2)) u_cnt2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .store_data(store_data),
        .rd_addr(rd_addr), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .set_flags(set_flags), .br_type(br_type), .br_target(br_target),
        .out_valid(c2_valid), .out_alu(c2_alu), .out_store_data(c2_store_data),
        .out_rd(c2_rd), .out_reg_wr(c2_reg_wr), .out_mem_rd(c2_mem_rd),
        .out_mem_wr(c2_mem_wr), .flag_z(c2_fz), .flag_n(c2_fn), .redirect(c2_redirect),
        .redirect_pc(c2_redirect_pc), .taken_cnt(c2_taken_cnt)
    );

    // Reference model: one MEM slot, a flag pair, and "a redirect is still owed".
    logic        m_valid, m_rw, m_mr, m_mw, m_fz, m_fn, m_pend;
    logic [31:0] m_alu, m_sd, m_pc;
    logic [5:0]  m_rd;
    int          m_cnt, m_cnt2;

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_fz = 0; m_fn = 0; m_pend = 0;
        m_alu = 0; m_sd = 0; m_pc = 0; m_rd = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge();
        bit go, cap, tk;
        go  = !stall || flush;
        cap = in_valid && !stall && !flush;
        tk  = (br_type == 2'd3) || (br_type == 2'd1 && m_fz) || (br_type == 2'd2 && m_fn);
        if (go) begin
            m_valid = cap;
            m_rw = cap && reg_wr;
            m_mr = cap && mem_rd;
            m_mw = cap && mem_wr;
            m_pend = cap && tk;
        end else begin
            m_pend = 0;  // a stalled cycle consumes the owed pulse
        end
        if (cap) begin
            m_alu = alu_out; m_sd = store_data; m_rd = rd_addr;
        end
        if (cap && tk) begin
            m_pc = br_target;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (cap && set_flags) begin
            m_fz = alu_z; m_fn = alu_n;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_reg_wr", 32'(out_reg_wr), 32'(m_rw));
        chk("out_mem_rd", 32'(out_mem_rd), 32'(m_mr));
        chk("out_mem_wr", 32'(out_mem_wr), 32'(m_mw));
        if (m_valid) begin
            chk("out_alu", out_alu, m_alu);
            chk("out_store_data", out_store_data, m_sd);
            chk("out_rd", 32'(out_rd), 32'(m_rd));
        end
        chk("flag_z", 32'(flag_z), 32'(m_fz));
        chk("flag_n", 32'(flag_n), 32'(m_fn));
        chk("redirect", 32'(redirect), 32'(m_pend));
        if (m_pend) chk("redirect_pc", redirect_pc, m_pc);
        chk("taken_cnt", 32'(taken_cnt), m_cnt);
        chk("taken_cnt_w2", 32'(c2_taken_cnt), m_cnt2);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        in_valid = 0; stall = 0; flush = 0; alu_out = 0; alu_z = 0; alu_n = 0;
        store_data = 0; rd_addr = 0; reg_wr = 0; mem_rd = 0; mem_wr = 0;
        set_flags = 0; br_type = 2'd0; br_target = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1;
    endtask

    int pulses;
    logic [31:0] held_alu;

    initial begin
        idle();
        rst_n = 1;
        model_reset();
        #2 rst_n = 0;
        #1 check_all();
        @(posedge clk);
        #2 rst_n = 1;

        // Counter saturation on the 2-bit instance: 1,2,3,3,3.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; br_type = 2'd3; br_target = 32'h200 + 32'(i);
            cycle();
            chk("cnt_w2_seq", 32'(c2_taken_cnt), (i < 3) ? i + 1 : 3);
        end
        idle();
        cycle();

        // Async reset while a taken JUMP is owed a redirect.
        in_valid = 1; br_type = 2'd3; br_target = 32'h80; reg_wr = 1; alu_out = 32'h1234;
        cycle();
        chk("jump_redirect_pre_reset", 32'(redirect), 1);
        stall = 1;
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_out_alu", out_alu, 0);
        chk("rst_out_reg_wr", 32'(out_reg_wr), 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_taken_cnt", 32'(taken_cnt), 0);
        @(posedge clk);
        #2 rst_n = 1;
        idle();
        cycle();
        chk("no_redirect_after_reset", 32'(redirect), 0);

        // SUB sets Z, then BRZ is taken with a single pulse.
        in_valid = 1; set_flags = 1; alu_out = 0; alu_z = 1; reg_wr = 1; rd_addr = 6'd3;
        cycle();
        chk("sub_flag_z", 32'(flag_z), 1);
        idle();
        in_valid = 1; br_type = 2'd1; br_target = 32'h40;
        cycle();
        chk("brz_redirect", 32'(redirect), 1);
        chk("brz_pc", redirect_pc, 32'h40);
        chk("brz_cnt", 32'(taken_cnt), 1);
        idle();
        cycle();
        chk("brz_pulse_end", 32'(redirect), 0);

        // BRN with N clear, then NEG+BRN (illegal combo) still sees old N.
        in_valid = 1; br_type = 2'd2; br_target = 32'h50;
        cycle();
        chk("brn1_not_taken", 32'(redirect), 0);
        set_flags = 1; alu_out = 32'hFFFF_FFFF; alu_n = 1; alu_z = 0;
        cycle();
        chk("brn2_not_taken", 32'(redirect), 0);
        chk("neg_flag_n", 32'(flag_n), 1);
        idle();

        // JUMP held by a 3-cycle stall fires exactly once.
        in_valid = 1; br_type = 2'd3; br_target = 32'h100; alu_out = 32'hCAFE; mem_wr = 1;
        pulses = 0;
        cycle();
        pulses += int'(redirect);
        held_alu = out_alu;
        alu_out = 32'hDEAD; stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            pulses += int'(redirect);
            chk("stall_hold_alu", out_alu, held_alu);
        end
        idle();
        cycle();
        pulses += int'(redirect);
        chk("stall_pulses", 32'(pulses), 1);
        chk("stall_cnt", 32'(taken_cnt), 2);

        // Flush beats stall: valid ADD with reg_wr becomes a bubble.
        in_valid = 1; stall = 1; flush = 1; reg_wr = 1; set_flags = 1; alu_z = 1; alu_n = 0;
        cycle();
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_reg_wr", 32'(out_reg_wr), 0);
        chk("flush_flag_n", 32'(flag_n), 1);
        idle();
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 9) < 8);
            stall      = ($urandom_range(0, 9) < 2);
            flush      = ($urandom_range(0, 9) < 1);
            alu_out    = $urandom;
            alu_z      = 1'($urandom);
            alu_n      = 1'($urandom);
            store_data = $urandom;
            rd_addr    = 6'($urandom);
            reg_wr     = 1'($urandom);
            mem_rd     = 1'($urandom);
            mem_wr     = 1'($urandom);
            set_flags  = ($urandom_range(0, 3) == 0);
            br_type    = 2'($urandom);
            br_target  = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
EX/MEM pipeline boundary directly downstream of the ALU. Each cycle it captures the ALU result, Z/N flags and the control fields travelling with the instruction. It keeps the architectural condition-flag register. It resolves BRZ/BRN/JUMP against those flags and issues a one-cycle redirect to fetch. It also supports stall (hold) and flush (bubble) from the hazard unit, and counts taken branches.

Parameters:
DATA_W, 32, datapath/PC width
RD_W, 6, destination register address width
CNT_W, 16, taken-branch counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX slot holds a real instruction
stall  in  1  hold all stage state this cycle
flush  in  1  load a bubble into the stage this cycle
alu_out  in  DATA_W  ALU result
alu_z  in  1  ALU zero flag
alu_n  in  1  ALU negative flag
store_data  in  DATA_W  Rt value for memory write
rd_addr  in  RD_W  destination register
reg_wr  in  1  instruction writes register file
mem_rd  in  1  instruction reads data memory
mem_wr  in  1  instruction writes data memory
set_flags  in  1  instruction updates Z/N
br_type  in  2  00 none, 01 BRZ, 10 BRN, 11 JUMP
br_target  in  DATA_W  branch target (PC+imm or register)
out_valid  out  1  MEM slot valid
out_alu  out  DATA_W  latched ALU result (memory address or writeback data)
out_store_data  out  DATA_W  latched store data
out_rd  out  RD_W  latched destination
out_reg_wr / out_mem_rd / out_mem_wr  out  1 each  latched controls, all forced 0 when out_valid=0
flag_z, flag_n  out  1 each  architectural flag register
redirect  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  DATA_W  latched branch target
taken_cnt  out  CNT_W  saturating taken-branch count

Behaviour:
- Reset (async, rst_n=0): every output and internal register 0, including out_valid, flags, redirect, redirect_pc, taken_cnt, redirect_done.
- Capture condition `acc = in_valid & ~stall & ~flush`. Latency: 1 cycle, input to out_* registers.
- On acc: load all out_* fields. out_valid=1.
- Flush: out_valid=0 and all out_* controls=0. Data fields may retain their old values. Flags are not updated. No redirect.
- Flush and stall in the same cycle: flush wins.
- in_valid=0 with no stall/flush: same as flush.
- Stall without flush: every register holds, including flags and taken_cnt.
- Flag register: on acc & set_flags, flag_z<=alu_z and flag_n<=alu_n. Otherwise hold.
- Branch resolution (combinational, at EX):
  - taken = BRZ & flag_z | BRN & flag_n | JUMP.
  - It uses the flag register value before this cycle's update; branches never set flags.
  - If set_flags and br_type≠00 are both asserted, that is illegal. The flag update still occurs and the branch still uses the old flags.
- Redirect:
  - On acc & taken: redirect_pc<=br_target and out_taken<=1. Otherwise out_taken<=0 on any non-stalled edge.
  - redirect = out_valid & out_taken & ~redirect_done.
  - redirect_done is set at the clock edge while redirect=1 and stall=1. It is cleared on any non-stalled edge.
  - Net effect: exactly one pulse per taken branch, even if the stage is stalled for N cycles.
  - The stage never flushes itself; the hazard unit converts redirect into a flush of the younger stages.
- taken_cnt increments on acc & taken. It saturates at all-ones and does not wrap.
- Reset mid-stall or mid-redirect: everything returns to 0 immediately. There is no pending redirect after reset.

Decomposition:
- Shared package cpu_pkg holds:
  - br_type encodings (BR_NONE, BR_Z, BR_N, BR_JUMP);
  - DATA_W / RD_W defaults;
  - the ALU opcode constants (ADD 000, SUB 101, NEG 110, PASS 111).
- One combinational sub-module, branch_resolve(br_type, flag_z, flag_n) -> taken, so decode/hazard logic can reuse it.

Test Plan:
- Reset: hold rst_n=0 mid-stream with a taken JUMP pending -> all outputs 0 asynchronously, no redirect after release.
- SUB with set_flags: alu_out=0, alu_z=1, followed by BRZ with br_target=0x40 -> flag_z=1 one cycle after the SUB. The BRZ captures, then redirect=1 for exactly 1 cycle, redirect_pc=0x40, taken_cnt=1.
- Flags not set: BRN with flag_n=0, then a NEG with set_flags producing 0xFFFFFFFF (n=1) issued in the same cycle as a second BRN -> first BRN not taken; the second BRN uses the old flags and is not taken; flag_n=1 afterwards.
- Stall for 3 cycles while a taken JUMP sits in the stage -> redirect high for exactly 1 cycle, out_* stable through the stall, taken_cnt incremented once.
- flush=1 and stall=1 together with a valid ADD carrying reg_wr=1 -> out_valid=0, out_reg_wr=0, flags unchanged.
- Counter: with CNT_W=2, 5 taken JUMPs -> taken_cnt reads 1,2,3,3,3.
